load_store_unit: RTL and testbench

//   Initiator side of the data-memory interface for the 16-bit RISC core.

---
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_load_store_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator toward Data_Memory, all outputs registered.
// Optional feature: define LSU_WRITE_VERIFY_EN to read back each store and flag mismatches on verify_err.
module load_store_unit #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned READ_WAIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              busy,
   output logic              verify_err,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   if (READ_WAIT == 0) begin : g_bad_read_wait
      $error("load_store_unit: READ_WAIT must be at least 1");
   end

   localparam int unsigned CntW = $clog2(READ_WAIT + 1);
   localparam logic [CntW-1:0] WaitInit = CntW'(READ_WAIT);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWrite,
`ifdef LSU_WRITE_VERIFY_EN
      StVerify,
`endif
      StResp
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_rd_q, mem_rd_d;
`ifdef LSU_WRITE_VERIFY_EN
   logic              verr_q, verr_d;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_ready_d  = 1'b0;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mem_we_d     = 1'b0;
      mem_rd_d     = 1'b0;
`ifdef LSU_WRITE_VERIFY_EN
      verr_d       = verr_q;
`endif
      case (state_q)
         StIdle: begin
            if (req_valid && req_ready_q) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (req_we) begin
                  state_d  = StWrite;
                  mem_we_d = 1'b1;
               end else begin
                  state_d  = StRead;
                  mem_rd_d = 1'b1;
                  cnt_d    = WaitInit;
               end
            end else begin
               req_ready_d = 1'b1;
            end
         end
         StRead: begin
            // Last wait cycle: data is valid for the address held this whole window
            if (cnt_q == CntOne) begin
               resp_data_d  = mem_read_data;
               resp_valid_d = 1'b1;
               state_d      = StResp;
            end else begin
               cnt_d    = cnt_q - CntOne;
               mem_rd_d = 1'b1;
            end
         end
         StWrite: begin
            resp_data_d = '0;
`ifdef LSU_WRITE_VERIFY_EN
            state_d     = StVerify;
            mem_rd_d    = 1'b1;
            cnt_d       = WaitInit;
`else
            state_d      = StResp;
            resp_valid_d = 1'b1;
`endif
         end
`ifdef LSU_WRITE_VERIFY_EN
         StVerify: begin
            if (cnt_q == CntOne) begin
               resp_data_d  = mem_read_data;
               resp_valid_d = 1'b1;
               verr_d       = verr_q | (mem_read_data != wdata_q);
               state_d      = StResp;
            end else begin
               cnt_d    = cnt_q - CntOne;
               mem_rd_d = 1'b1;
            end
         end
`endif
         StResp: begin
            state_d     = StIdle;
            req_ready_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         busy_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mem_we_q     <= 1'b0;
         mem_rd_q     <= 1'b0;
`ifdef LSU_WRITE_VERIFY_EN
         verr_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         busy_q       <= busy_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mem_we_q     <= mem_we_d;
         mem_rd_q     <= mem_rd_d;
`ifdef LSU_WRITE_VERIFY_EN
         verr_q       <= verr_d;
`endif
      end
   end

   assign req_ready       = req_ready_q;
   assign resp_valid      = resp_valid_q;
   assign resp_data       = resp_data_q;
   assign busy            = busy_q;
   assign mem_access_addr = addr_q;
   assign mem_write_data  = wdata_q;
   assign mem_write_en    = mem_we_q;
   assign mem_read        = mem_rd_q;
`ifdef LSU_WRITE_VERIFY_EN
   assign verify_err      = verr_q;
`else
   assign verify_err      = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: DUT a uses READ_WAIT=1, DUT b uses READ_WAIT=3; each has a memory model.
// Responses are scored against per-DUT expected-data queues filled when requests are driven.
module tb_load_store_unit;

   localparam int unsigned RwA = 1;
   localparam int unsigned RwB = 3;
`ifdef LSU_WRITE_VERIFY_EN
   localparam bit VerifyOn = 1'b1;
`else
   localparam bit VerifyOn = 1'b0;
`endif
   localparam int StoreLatA = VerifyOn ? RwA + 2 : 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        rst_a, a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_busy, a_verify_err;
   logic [15:0] a_req_addr, a_req_wdata, a_resp_data, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic        a_mem_we, a_mem_rd;
   logic        rst_b, b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_busy, b_verify_err;
   logic [15:0] b_req_addr, b_req_wdata, b_resp_data, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic        b_mem_we, b_mem_rd;

   load_store_unit #(.ADDR_W(16), .DATA_W(16), .READ_WAIT(RwA)) dut_a (
      .clk(clk), .rst(rst_a), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata), .resp_valid(a_resp_valid),
      .resp_data(a_resp_data), .busy(a_busy), .verify_err(a_verify_err),
      .mem_access_addr(a_mem_addr), .mem_write_data(a_mem_wdata), .mem_write_en(a_mem_we),
      .mem_read(a_mem_rd), .mem_read_data(a_mem_rdata)
   );

   load_store_unit #(.ADDR_W(16), .DATA_W(16), .READ_WAIT(RwB)) dut_b (
      .clk(clk), .rst(rst_b), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
      .resp_data(b_resp_data), .busy(b_busy), .verify_err(b_verify_err),
      .mem_access_addr(b_mem_addr), .mem_write_data(b_mem_wdata), .mem_write_en(b_mem_we),
      .mem_read(b_mem_rd), .mem_read_data(b_mem_rdata)
   );

   // Memory models: unwritten words read as addr^1; stuck0 forces address 0 to read 0x0001
   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   bit          wr_a [256];
   bit          wr_b [256];
   bit          stuck0 = 1'b0;

   always @(posedge clk) begin
      if (a_mem_we) begin
         mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
         wr_a[a_mem_addr[7:0]]  <= 1'b1;
      end
      if (b_mem_we) begin
         mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
         wr_b[b_mem_addr[7:0]]  <= 1'b1;
      end
   end

   assign a_mem_rdata = (stuck0 && a_mem_addr == 16'h0000) ? 16'h0001 :
                        wr_a[a_mem_addr[7:0]] ? mem_a[a_mem_addr[7:0]] : (a_mem_addr ^ 16'h0001);
   assign b_mem_rdata = wr_b[b_mem_addr[7:0]] ? mem_b[b_mem_addr[7:0]] : (b_mem_addr ^ 16'h0001);

   logic [15:0] q_a [$];
   logic [15:0] q_b [$];
   logic [15:0] exp_a, exp_b;
   int          a_resp_cnt = 0;
   int          b_resp_cnt = 0;

   always @(negedge clk) begin
      if (a_resp_valid === 1'b1) begin
         a_resp_cnt++;
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected_resp: got resp_data=%h, required no response", a_resp_data);
         end else begin
            exp_a = q_a.pop_front();
            if (a_resp_data !== exp_a) begin
               errors++;
               $display("FAIL a_resp_data: got %h, expected %h", a_resp_data, exp_a);
            end
         end
      end
      if (b_resp_valid === 1'b1) begin
         b_resp_cnt++;
         checks++;
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected_resp: got resp_data=%h, required no response", b_resp_data);
         end else begin
            exp_b = q_b.pop_front();
            if (b_resp_data !== exp_b) begin
               errors++;
               $display("FAIL b_resp_data: got %h, expected %h", b_resp_data, exp_b);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1;
      rst_b = 1'b1;
      tick();
      tick();
      checks++;
      if ({a_req_ready, a_resp_valid, a_resp_data, a_busy, a_verify_err, a_mem_addr, a_mem_wdata,
           a_mem_we, a_mem_rd} !== '0) begin
         errors++;
         $display("FAIL a_reset_outputs: got ready=%b busy=%b addr=%h, expected all 0",
                  a_req_ready, a_busy, a_mem_addr);
      end
      checks++;
      if ({b_req_ready, b_resp_valid, b_resp_data, b_busy, b_verify_err, b_mem_addr, b_mem_wdata,
           b_mem_we, b_mem_rd} !== '0) begin
         errors++;
         $display("FAIL b_reset_outputs: got ready=%b busy=%b addr=%h, expected all 0",
                  b_req_ready, b_busy, b_mem_addr);
      end
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick();
      checks++;
      if ({a_req_ready, a_busy, b_req_ready, b_busy} !== 4'b1010) begin
         errors++;
         $display("FAIL post_reset_ready: got %b, expected 1010",
                  {a_req_ready, a_busy, b_req_ready, b_busy});
      end
   endtask

   task automatic test_load();
      a_req_valid = 1'b1;
      a_req_we    = 1'b0;
      a_req_addr  = 16'h0003;
      q_a.push_back(16'h0002);
      tick();
      a_req_valid = 1'b0;
      checks++;
      if ({a_mem_rd, a_mem_we, a_busy, a_req_ready, a_resp_valid} !== 5'b10100 ||
          a_mem_addr !== 16'h0003) begin
         errors++;
         $display("FAIL load_cycle1: got rd/we/busy/rdy/rv=%b addr=%h, expected 10100 addr=0003",
                  {a_mem_rd, a_mem_we, a_busy, a_req_ready, a_resp_valid}, a_mem_addr);
      end
      tick();
      checks++;
      if ({a_mem_rd, a_resp_valid} !== 2'b01 || a_resp_data !== 16'h0002) begin
         errors++;
         $display("FAIL load_cycle2: got rd=%b rv=%b data=%h, expected rd=0 rv=1 data=0002",
                  a_mem_rd, a_resp_valid, a_resp_data);
      end
      tick();
      checks++;
      if ({a_resp_valid, a_req_ready, a_busy} !== 3'b010 || a_mem_addr !== 16'h0003 ||
          a_resp_data !== 16'h0002) begin
         errors++;
         $display("FAIL load_cycle3: got rv/rdy/busy=%b addr=%h data=%h, expected 010 0003 0002",
                  {a_resp_valid, a_req_ready, a_busy}, a_mem_addr, a_resp_data);
      end
   endtask

   task automatic test_store();
      logic [15:0] exp;
      exp = VerifyOn ? 16'hABCD : 16'h0000;
      a_req_valid = 1'b1;
      a_req_we    = 1'b1;
      a_req_addr  = 16'h0005;
      a_req_wdata = 16'hABCD;
      q_a.push_back(exp);
      tick();
      a_req_valid = 1'b0;
      checks++;
      if ({a_mem_we, a_mem_rd, a_resp_valid} !== 3'b100 || a_mem_addr !== 16'h0005 ||
          a_mem_wdata !== 16'hABCD) begin
         errors++;
         $display("FAIL store_cycle1: got we/rd/rv=%b addr=%h data=%h, expected 100 0005 abcd",
                  {a_mem_we, a_mem_rd, a_resp_valid}, a_mem_addr, a_mem_wdata);
      end
      for (int k = 2; k <= StoreLatA; k++) begin
         tick();
         checks++;
         if (a_mem_we !== 1'b0 || a_resp_valid !== (k == StoreLatA)) begin
            errors++;
            $display("FAIL store_cycle%0d: got we=%b rv=%b, expected we=0 rv=%b",
                     k, a_mem_we, a_resp_valid, (k == StoreLatA));
         end
      end
      checks++;
      if (a_resp_data !== exp) begin
         errors++;
         $display("FAIL store_resp_data: got %h, expected %h", a_resp_data, exp);
      end
      tick();
      checks++;
      if ({a_req_ready, a_resp_valid} !== 2'b10) begin
         errors++;
         $display("FAIL store_ready_return: got rdy/rv=%b, expected 10", {a_req_ready, a_resp_valid});
      end
   endtask

   task automatic test_back_to_back();
      logic        we [3];
      logic [15:0] ad [3];
      logic [15:0] wd [3];
      logic [15:0] ex [3];
      int          k;
      int          start_cnt;
      bit          was_ready;
      we[0] = 1'b1; ad[0] = 16'h0010; wd[0] = 16'h5A5A; ex[0] = VerifyOn ? 16'h5A5A : 16'h0000;
      we[1] = 1'b0; ad[1] = 16'h0010; wd[1] = 16'hFFFF; ex[1] = 16'h5A5A;
      we[2] = 1'b0; ad[2] = 16'h0005; wd[2] = 16'h0000; ex[2] = 16'hABCD;
      start_cnt   = a_resp_cnt;
      k           = 0;
      a_req_valid = 1'b1;
      a_req_we    = we[0];
      a_req_addr  = ad[0];
      a_req_wdata = wd[0];
      q_a.push_back(ex[0]);
      for (int cyc = 0; cyc < 60 && k < 3; cyc++) begin
         was_ready = a_req_ready;
         tick();
         if (was_ready) begin
            k++;
            if (k < 3) begin
               a_req_we    = we[k];
               a_req_addr  = ad[k];
               a_req_wdata = wd[k];
               q_a.push_back(ex[k]);
            end else begin
               a_req_valid = 1'b0;
            end
         end
         if (a_busy === 1'b1) begin
            checks++;
            if (a_req_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_ready_while_busy: got req_ready=%b, expected 0", a_req_ready);
            end
         end
      end
      a_req_valid = 1'b0;
      checks++;
      if (k != 3) begin
         errors++;
         $display("FAIL b2b_accepts: got %0d accepts, expected 3", k);
      end
      for (int cyc = 0; cyc < 20 && a_resp_cnt < start_cnt + 3; cyc++) tick();
      tick();
      checks++;
      if (a_resp_cnt - start_cnt != 3) begin
         errors++;
         $display("FAIL b2b_resp_count: got %0d responses, expected 3", a_resp_cnt - start_cnt);
      end
   endtask

   task automatic test_reset_mid_read();
      int start_cnt;
      b_req_valid = 1'b1;
      b_req_we    = 1'b0;
      b_req_addr  = 16'h0007;
      tick();
      b_req_valid = 1'b0;
      tick();
      checks++;
      if (b_mem_rd !== 1'b1 || b_mem_addr !== 16'h0007) begin
         errors++;
         $display("FAIL mid_read_active: got rd=%b addr=%h, expected rd=1 addr=0007",
                  b_mem_rd, b_mem_addr);
      end
      rst_b = 1'b1;
      tick();
      checks++;
      if ({b_req_ready, b_resp_valid, b_resp_data, b_busy, b_verify_err, b_mem_addr, b_mem_wdata,
           b_mem_we, b_mem_rd} !== '0) begin
         errors++;
         $display("FAIL mid_read_reset: got rd=%b busy=%b addr=%h, expected all 0",
                  b_mem_rd, b_busy, b_mem_addr);
      end
      rst_b = 1'b0;
      start_cnt = b_resp_cnt;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (b_resp_cnt != start_cnt || b_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_read_aftermath: got %0d responses ready=%b, expected 0 responses ready=1",
                  b_resp_cnt - start_cnt, b_req_ready);
      end
      b_req_valid = 1'b1;
      b_req_addr  = 16'h0009;
      q_b.push_back(16'h0008);
      tick();
      b_req_valid = 1'b0;
      for (int k = 1; k <= RwB + 1; k++) begin
         checks++;
         if (b_mem_rd !== (k <= RwB) || b_resp_valid !== (k == RwB + 1)) begin
            errors++;
            $display("FAIL reload_cycle%0d: got rd=%b rv=%b, expected rd=%b rv=%b",
                     k, b_mem_rd, b_resp_valid, (k <= RwB), (k == RwB + 1));
         end
         tick();
      end
   endtask

`ifdef LSU_WRITE_VERIFY_EN
   task automatic test_verify();
      int start_cnt;
      stuck0 = 1'b1;
      checks++;
      if (a_verify_err !== 1'b0) begin
         errors++;
         $display("FAIL verify_initial: got %b, expected 0", a_verify_err);
      end
      for (int n = 0; n < 2; n++) begin
         start_cnt   = a_resp_cnt;
         a_req_valid = 1'b1;
         a_req_we    = 1'b1;
         a_req_addr  = 16'h0000;
         a_req_wdata = (n == 0) ? 16'h1234 : 16'h0001;
         q_a.push_back(16'h0001);
         tick();
         a_req_valid = 1'b0;
         for (int cyc = 0; cyc < 20 && a_resp_cnt == start_cnt; cyc++) tick();
         tick();
         checks++;
         if (a_resp_cnt != start_cnt + 1 || a_verify_err !== 1'b1) begin
            errors++;
            $display("FAIL verify_store%0d: got resp=%0d err=%b, expected resp=1 err=1",
                     n, a_resp_cnt - start_cnt, a_verify_err);
         end
      end
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      checks++;
      if (a_verify_err !== 1'b0) begin
         errors++;
         $display("FAIL verify_clear: got %b, expected 0", a_verify_err);
      end
      stuck0 = 1'b0;
      tick();
   endtask
`endif

   task automatic test_drain();
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending responses, expected 0/0", q_a.size(), q_b.size());
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
      #1;
      test_reset();
      test_load();
      test_store();
      test_back_to_back();
      test_reset_mid_read();
`ifdef LSU_WRITE_VERIFY_EN
      test_verify();
`endif
      tick();
      test_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
